// File: rtl/nand_reduce_sweeper.sv
// nand_reduce_sweeper: exhaustive truth-table checker for NAND-only reductions.
// Walks every N_IN-bit input combination and streams one row per clock.
// Each row compares a network of 2-input NANDs against a behavioural reduction.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; op is latched when start is accepted
// SWEEP | one row per cycle without hold; the counter walks 0..2^N_IN-1
// DONE  | sweep finished or was rejected; done/bad_op register next edge
module nand_reduce_sweeper #(
  parameter int N_IN = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            hold,
  input  logic            inject_fault,
  output logic            busy,
  output logic            row_valid,
  output logic [N_IN-1:0] row_in,
  output logic            row_out,
  output logic            mismatch,
  output logic [N_IN:0]   err_count,
  output logic            done,
  output logic            bad_op
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter has one spare bit, so the last-row compare never wraps.
  localparam logic [N_IN:0] LAST_ROW = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0] ERR_MAX  = {1'b1, {N_IN{1'b0}}};

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [N_IN:0]   cnt_q;
  logic [N_IN-1:0] x;
  logic            accept;
  logic            emit;
  logic            net_res;
  logic            golden;
  logic            row_res;
  logic            and_acc, or_acc, xor_acc;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic inv(input logic a);
    return nand2(a, a);
  endfunction

  // Classic four-NAND XOR cell.
  function automatic logic xor_cell(input logic a, input logic b);
    logic t;
    t = nand2(a, b);
    return nand2(nand2(a, t), nand2(b, t));
  endfunction

  assign x = cnt_q[N_IN-1:0];

  // NAND-only reduction chains plus the behavioural golden reduction.
  always_comb begin
    and_acc = x[0];
    or_acc  = x[0];
    xor_acc = x[0];
    for (int i = 1; i < N_IN; i++) begin
      and_acc = inv(nand2(and_acc, x[i]));
      or_acc  = nand2(inv(or_acc), inv(x[i]));
      xor_acc = xor_cell(xor_acc, x[i]);
    end
    net_res = 1'b0;
    golden  = 1'b0;
    case (op_q)
      3'd0: begin net_res = inv(and_acc); golden = ~&x; end
      3'd1: begin net_res = and_acc;      golden = &x;  end
      3'd2: begin net_res = or_acc;       golden = |x;  end
      3'd3: begin net_res = inv(or_acc);  golden = ~|x; end
      3'd4: begin net_res = xor_acc;      golden = ^x;  end
      3'd5: begin net_res = inv(xor_acc); golden = ~^x; end
      default: begin net_res = 1'b0;      golden = 1'b0; end
    endcase
    row_res = net_res ^ inject_fault;
  end

  // Next-state decode; a start is refused during the cycle done is visible.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done) begin
          accept  = 1'b1;
          state_d = (op <= 3'd5) ? SWEEP : DONE;
        end
      end
      SWEEP: begin
        if (!hold) begin
          emit = 1'b1;
          if (cnt_q == LAST_ROW) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, row and status registers; busy covers the done cycle too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      row_valid <= 1'b0;
      row_in    <= '0;
      row_out   <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
      done      <= 1'b0;
      bad_op    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE) || (state_q == DONE);
      done      <= (state_q == DONE);
      bad_op    <= (state_q == DONE) && (op_q > 3'd5);
      row_valid <= emit;
      if (accept) begin
        op_q      <= op;
        cnt_q     <= '0;
        err_count <= '0;
      end
      if (emit) begin
        row_in   <= x;
        row_out  <= row_res;
        mismatch <= (row_res != golden);
        cnt_q    <= cnt_q + 1'b1;
        if ((row_res != golden) && (err_count != ERR_MAX))
          err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nand_reduce_sweeper.sv
// Scoreboard bench for nand_reduce_sweeper at N_IN=3: the driver predicts each
// row/done event with its cycle; a negedge monitor pops and compares.
module tb_nand_reduce_sweeper;

  localparam int N    = 3;
  localparam int ROWS = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic         hold;
  logic         inject_fault;
  logic         busy;
  logic         row_valid;
  logic [N-1:0] row_in;
  logic         row_out;
  logic         mismatch;
  logic [N:0]   err_count;
  logic         done;
  logic         bad_op;

  typedef struct {
    int           cyc;
    bit           is_done;
    logic [N-1:0] rin;
    logic         rout;
    logic         mm;
    logic [N:0]   err;
    logic         bad;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  nand_reduce_sweeper #(.N_IN(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .hold(hold),
    .inject_fault(inject_fault), .busy(busy), .row_valid(row_valid),
    .row_in(row_in), .row_out(row_out), .mismatch(mismatch),
    .err_count(err_count), .done(done), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Reference: every function is a rule on the number of ones in the row.
  function automatic logic ref_out(input logic [2:0] o, input int k);
    int ones;
    ones = $countones(k);
    case (o)
      3'd0:    return ones != N;
      3'd1:    return ones == N;
      3'd2:    return ones > 0;
      3'd3:    return ones == 0;
      3'd4:    return (ones % 2) == 1;
      default: return (ones % 2) == 0;
    endcase
  endfunction

  task automatic push_row(input int c, input int k, input logic r, input logic m, input int errs);
    exp_t e;
    e.cyc = c; e.is_done = 1'b0; e.rin = k[N-1:0]; e.rout = r; e.mm = m;
    e.err = errs[N:0]; e.bad = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c, input int errs, input logic b);
    exp_t e;
    e.cyc = c; e.is_done = 1'b1; e.rin = '0; e.rout = 1'b0; e.mm = 1'b0;
    e.err = errs[N:0]; e.bad = b;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the expected event whenever the DUT presents a row or done.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("missing_output", 64'(cyc), 64'(exp_q[0].cyc));
      void'(exp_q.pop_front());
    end
    if (row_valid || done) begin
      if (exp_q.size() == 0)
        check("unexpected_output", 64'({row_valid, done}), 64'(0));
      else if (exp_q[0].cyc != cyc)
        check("output_cycle", 64'(cyc), 64'(exp_q[0].cyc));
      else begin
        me = exp_q.pop_front();
        if (me.is_done)
          check("done_event", 64'({row_valid, done, busy, bad_op, err_count}),
                64'({1'b0, 1'b1, 1'b1, me.bad, me.err}));
        else
          check("row", 64'({row_valid, done, busy, row_in, row_out, mismatch, err_count, bad_op}),
                64'({1'b1, 1'b0, 1'b1, me.rin, me.rout, me.mm, me.err, 1'b0}));
      end
    end
  end

  // hmode: 0 none, 1 random, 2 three holds after the second row.
  // fmode: 0 none, 1 every row, 2 random.
  task automatic do_sweep(input logic [2:0] o, input int hmode, input int fmode, input bit poke);
    int k, errs, held, guard;
    bit h, f;
    @(negedge clk);
    start = 1'b1; op = o;
    hold = 1'($urandom_range(0, 1)); inject_fault = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7));
    check("busy_after_start", 64'(busy), 64'(1));
    if (o > 3'd5) begin
      hold = 1'b0;
      push_done(cyc + 1, 0, 1'b1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_bad_op", 64'(busy), 64'(0));
      return;
    end
    k = 0; errs = 0; held = 0; guard = 0;
    while (k < ROWS && guard < 400) begin
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      op = 3'($urandom_range(0, 7));
      case (hmode)
        0:       h = 1'b0;
        1:       h = ($urandom_range(0, 3) == 0);
        default: h = (k == 2 && held < 3);
      endcase
      if (h) held++;
      f = (fmode == 0) ? 1'b0 : (fmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      hold = h; inject_fault = f;
      if (!h) begin
        errs += int'(f);
        push_row(cyc + 1, k, ref_out(o, k) ^ f, f, errs);
        k++;
      end
      guard++;
      @(negedge clk);
    end
    if (k < ROWS) check("sweep_guard", 64'(k), 64'(ROWS));
    push_done(cyc + 1, errs, 1'b0);
    start = 1'b1; hold = 1'b1;
    @(negedge clk);
    hold = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0; hold = 1'b0; inject_fault = 1'b0;
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  task automatic reset_mid_sweep();
    @(negedge clk);
    start = 1'b1; op = 3'd2; hold = 1'b0; inject_fault = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push_row(cyc + 1, k, ref_out(3'd2, k), 1'b0, 0);
      @(negedge clk);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("reset_mid_sweep",
          64'({busy, row_valid, row_in, row_out, mismatch, err_count, done, bad_op}), 64'(0));
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; hold = 1'b0; inject_fault = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state",
          64'({busy, row_valid, row_in, row_out, mismatch, err_count, done, bad_op}), 64'(0));
    rst = 1'b0;
    do_sweep(3'd4, 0, 0, 1'b0);
    do_sweep(3'd0, 0, 1, 1'b0);
    do_sweep(3'd1, 2, 0, 1'b0);
    do_sweep(3'd2, 0, 0, 1'b1);
    do_sweep(3'd6, 0, 0, 1'b0);
    do_sweep(3'd7, 0, 0, 1'b0);
    reset_mid_sweep();
    do_sweep(3'd3, 0, 0, 1'b0);
    for (int i = 0; i < 30; i++)
      do_sweep(3'($urandom_range(0, 7)), 1, 2, 1'b1);
    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
